irrigation_zone_ctrl: RTL and testbench
=======================================

// Module: irrigation_zone_ctrl
// PURPOSE
//  Parametrised, clocked successor of the tank/irrigation controller. Debounces
//  N_LEVELS tank level sensors and per-zone soil/air/temperature sensors, and
//  runs a hysteretic refill valve FSM with fault detection. A round-robin
//  scheduler irrigates one zone at a time, choosing sprinkler or drip per zone,
//  with a max-run timer and a forced rest period.
// PARAMETERS
//  N_ZONES        4    number of irrigation zones (1..16)
//  N_LEVELS       3    tank level sensors, thermometer coded, bit0 = lowest (2..8)
//  DEB_CYCLES     4    consecutive equal samples required to accept a sensor change (>=1)
//  REFILL_BELOW   2    valve reopens when wet-sensor count < this (1..N_LEVELS)
//  SPRINK_LEVEL   2    minimum wet-sensor count to run a sprinkler (1..N_LEVELS)
//  MAX_ON_CYCLES  1000 max RUN length per zone, in cycles (>=1)
//  REST_CYCLES    200  REST length after a timeout, in cycles (>=1)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst_n         in   1         asynchronous, active-low reset
//  level         in   N_LEVELS  raw tank sensors, 1 = water at sensor
//  soil_dry      in   N_ZONES   raw, 1 = zone soil needs water
//  air_dry       in   N_ZONES   raw, 1 = low air humidity at zone
//  hot           in   N_ZONES   raw, 1 = high temperature at zone
//  water_supply  out  1         refill valve open
//  error         out  1         tank sensor pattern inconsistent
//  alarm         out  1         error, or tank empty while any zone demands water
//  sprinkler     out  N_ZONES   one-hot sprinkler valve enables
//  drip          out  N_ZONES   one-hot drip valve enables
//  zone_idx      out  clog2(N_ZONES) zone in RUN/REST (last served when IDLE)
//  busy          out  1         scheduler in RUN or REST
// BEHAVIOUR
//  Reset (async, immediate, also mid-run): all outputs 0, zone_idx 0, rr pointer 0,
//   debounced sensors 0, tank FSM T_IDLE, scheduler S_IDLE, all counters 0.
//  Inputs: 2-flop synchroniser, then per-bit debounce. The debounced bit takes the
//   synchronised value on the edge where it has differed from the debounced bit
//   for DEB_CYCLES consecutive cycles. A glitch shorter than that is ignored.
//   lvl_cnt = number of debounced level bits set.
//  Tank FSM (registered outputs, 1 cycle after state change):
//   fault = debounced level not thermometer (a set bit above a clear bit).
//   Any state -> T_FAULT on fault (highest priority). T_FAULT -> T_IDLE when fault clears.
//   T_IDLE -> T_FILL when lvl_cnt < REFILL_BELOW. T_FILL -> T_IDLE when lvl_cnt == N_LEVELS.
//   water_supply = (state==T_FILL). error = (state==T_FAULT).
//   alarm = error | (lvl_cnt==0 & |soil_dry_deb).
//  Scheduler:
//   S_IDLE: if no fault, search zones rr, rr+1, ... wrapping modulo N_ZONES. Pick the
//    first zone with soil_dry_deb=1 and lvl_cnt>=1.
//   Mode, latched at entry: drip if hot_deb|air_dry_deb or lvl_cnt<SPRINK_LEVEL, else sprinkler.
//   If a zone is found: S_RUN, zone_idx=z, run counter=0, rr=z+1 (wrapping).
//   S_RUN: exactly one bit of sprinkler|drip set, at zone_idx. Evaluated each cycle:
//    - fault, soil_dry_deb[z]=0, or level below mode minimum (1 for drip,
//      SPRINK_LEVEL for sprinkler) -> S_IDLE, valve off next edge.
//    - else run counter == MAX_ON_CYCLES-1 -> S_REST.
//    Valve therefore stays on exactly MAX_ON_CYCLES cycles on timeout.
//   S_REST: valves off, counts REST_CYCLES, then S_IDLE.
//   Simultaneous fault and timeout: fault wins (-> S_IDLE).
//   Zone demand changing during RUN does not alter the mode until the next entry.
//   Only one zone valve is ever open. sprinkler & drip == 0 at all times.
//   Counters saturate and never wrap. N_ZONES=1 makes rr constant 0.
// TESTING
//  1 Reset mid-RUN (zone 2 sprinkling): rst_n low -> all outputs 0 asynchronously,
//    before the next clk edge. After release, rr restarts at zone 0.
//  2 level=3'b111 then 3'b001, held -> water_supply rises 2+DEB_CYCLES+1 cycles after
//    the change. It stays 1 until level=3'b111 is debounced. A 3-cycle glitch to 3'b000
//    is ignored (DEB_CYCLES=4).
//  3 level=3'b101 held -> error=1, alarm=1, water_supply=0, no valves on.
//    Then level=3'b011 -> error clears, and fill resumes only if lvl_cnt<REFILL_BELOW.
//  4 level=3'b111, soil_dry=4'b1010, hot=0, air_dry=0 -> zone1 sprinkler on;
//    soil_dry[1]->0 -> zone3 sprinkler next; zone1 is not reselected before zone3.
//  5 Zone0 dry and hot, MAX_ON_CYCLES=8, REST_CYCLES=5 -> drip[0] high exactly 8 cycles,
//    5 cycles of busy with valves off, then drip[0] again.
//  6 Sprinkler running at lvl_cnt=2; level drops to 3'b001 -> sprinkler off.
//    Same zone restarts as drip (lvl_cnt=1 < SPRINK_LEVEL).

Source files
------------

// File: rtl/irrigation_zone_if.sv
// Sensor and valve bundle for the irrigation zone controller.
//   master : environment side, drives the raw sensor bits and observes the valves
//   slave  : controller side, samples the raw sensors and drives the valve and status lines
//   level        N_LEVELS  raw tank sensors, bit0 = lowest, 1 = water present
//   soil_dry     N_ZONES   raw, 1 = zone soil needs water
//   air_dry      N_ZONES   raw, 1 = low air humidity at zone
//   hot          N_ZONES   raw, 1 = high temperature at zone
//   water_supply 1         refill valve open
//   error        1         tank sensor pattern inconsistent
//   alarm        1         error, or tank empty while any zone demands water
//   sprinkler    N_ZONES   one-hot sprinkler enables
//   drip         N_ZONES   one-hot drip enables
//   zone_idx     ZW        zone in RUN/REST, last served zone when idle
//   busy         1         scheduler in RUN or REST
interface irrigation_zone_if #(
  parameter int N_ZONES  = 4,
  parameter int N_LEVELS = 3
);
  localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  logic [N_LEVELS-1:0] level;
  logic [N_ZONES-1:0]  soil_dry;
  logic [N_ZONES-1:0]  air_dry;
  logic [N_ZONES-1:0]  hot;
  logic                water_supply;
  logic                error;
  logic                alarm;
  logic [N_ZONES-1:0]  sprinkler;
  logic [N_ZONES-1:0]  drip;
  logic [ZW-1:0]       zone_idx;
  logic                busy;

  modport master (
    output level, soil_dry, air_dry, hot,
    input  water_supply, error, alarm, sprinkler, drip, zone_idx, busy
  );

  modport slave (
    input  level, soil_dry, air_dry, hot,
    output water_supply, error, alarm, sprinkler, drip, zone_idx, busy
  );
endinterface

// File: rtl/irrigation_zone_ctrl.sv
// Tank refill and round-robin zone irrigation controller.
// Raw sensors pass through a two-flop synchroniser and a per-bit debounce.
// A tank FSM drives the refill valve with hysteresis and flags inconsistent
// level patterns. A scheduler serves one zone at a time (sprinkler or drip,
// chosen on entry), bounds each run and enforces a rest period after a timeout.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sensor inputs and valve/status outputs (slave side)
module irrigation_zone_ctrl #(
  parameter int N_ZONES       = 4,
  parameter int N_LEVELS      = 3,
  parameter int DEB_CYCLES    = 4,
  parameter int REFILL_BELOW  = 2,
  parameter int SPRINK_LEVEL  = 2,
  parameter int MAX_ON_CYCLES = 1000,
  parameter int REST_CYCLES   = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  irrigation_zone_if.slave  bus
);
  localparam int ZW  = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int NIN = N_LEVELS + 3 * N_ZONES;
  localparam int DW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int LW  = $clog2(N_LEVELS + 1);
  localparam int TMAX = (MAX_ON_CYCLES > REST_CYCLES) ? MAX_ON_CYCLES : REST_CYCLES;
  localparam int CW  = $clog2(TMAX + 1);

  typedef enum logic [1:0] {T_IDLE, T_FILL, T_FAULT} tank_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REST} sched_t;

  // ---------------- synchroniser and debounce ----------------
  logic [NIN-1:0]          raw, sync1, sync2, deb;
  logic [NIN-1:0][DW-1:0]  deb_cnt;

  assign raw = {bus.hot, bus.air_dry, bus.soil_dry, bus.level};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours (sync2 sees the old sync1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // deb_cnt counts consecutive cycles the synchronised bit disagrees with the
  // accepted bit; the new value is taken on the DEB_CYCLES-th such edge.
  // NOTE: the per-bit counter array is small flop storage, not RAM, so it is
  // reset with everything else to give a clean debounce start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [N_LEVELS-1:0] level_deb;
  logic [N_ZONES-1:0]  soil_deb, air_deb, hot_deb;
  assign level_deb = deb[N_LEVELS-1:0];
  assign soil_deb  = deb[N_LEVELS +: N_ZONES];
  assign air_deb   = deb[N_LEVELS + N_ZONES +: N_ZONES];
  assign hot_deb   = deb[N_LEVELS + 2 * N_ZONES +: N_ZONES];

  logic [LW-1:0] lvl_cnt;
  logic          fault;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lvl_cnt = '0;
    fault   = 1'b0;
    for (int i = 0; i < N_LEVELS; i++) lvl_cnt = lvl_cnt + LW'(level_deb[i]);
    // A wet sensor sitting above a dry one cannot happen with a real water column.
    for (int i = 0; i < N_LEVELS - 1; i++)
      if (level_deb[i+1] && !level_deb[i]) fault = 1'b1;
  end

  // ---------------- tank FSM ----------------
  tank_t tank_q, tank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tank_q <= T_IDLE;
    else        tank_q <= tank_d;
  end

  always_comb begin
    tank_d = tank_q;
    if (fault) begin
      tank_d = T_FAULT;
    end else begin
      case (tank_q)
        T_FAULT: tank_d = T_IDLE;
        T_IDLE:  if (lvl_cnt < LW'(REFILL_BELOW)) tank_d = T_FILL;
        T_FILL:  if (lvl_cnt == LW'(N_LEVELS)) tank_d = T_IDLE;
        default: tank_d = T_IDLE;
      endcase
    end
  end

  // ---------------- zone scheduler ----------------
  sched_t        sched_q, sched_d;
  logic [ZW-1:0] zone_q, zone_d, rr_q, rr_d, pick;
  logic          drip_q, drip_d, found, drip_sel, run_abort;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [ZW-1:0] wrap_add(input logic [ZW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_ZONES) s = s - N_ZONES;
    return ZW'(s);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_q <= S_IDLE;
      zone_q  <= '0;
      rr_q    <= '0;
      drip_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sched_q <= sched_d;
      zone_q  <= zone_d;
      rr_q    <= rr_d;
      drip_q  <= drip_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    // Scan from the far end so the zone nearest the pointer is the last write.
    for (int k = N_ZONES - 1; k >= 0; k--) begin
      if (soil_deb[wrap_add(rr_q, k)] && lvl_cnt != '0) begin
        found = 1'b1;
        pick  = wrap_add(rr_q, k);
      end
    end
    drip_sel  = hot_deb[pick] | air_deb[pick] | (lvl_cnt < LW'(SPRINK_LEVEL));
    run_abort = fault | ~soil_deb[zone_q] |
                (lvl_cnt < (drip_q ? LW'(1) : LW'(SPRINK_LEVEL)));
  end

  always_comb begin
    sched_d = sched_q;
    zone_d  = zone_q;
    rr_d    = rr_q;
    drip_d  = drip_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (sched_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fault && found) begin
          sched_d = S_RUN;
          zone_d  = pick;
          rr_d    = (pick == ZW'(N_ZONES - 1)) ? '0 : pick + 1'b1;
          drip_d  = drip_sel;
        end
      end
      S_RUN: begin
        // Abort is tested first so a fault coinciding with timeout skips REST.
        if (run_abort) begin
          sched_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MAX_ON_CYCLES - 1)) begin
          sched_d = S_REST;
          cnt_d   = '0;
        end
      end
      S_REST: begin
        if (cnt_q == CW'(REST_CYCLES - 1)) begin
          sched_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        sched_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- outputs ----------------
  logic [N_ZONES-1:0] sprinkler, drip;

  always_comb begin
    sprinkler = '0;
    drip      = '0;
    if (sched_q == S_RUN) begin
      if (drip_q) drip[zone_q]      = 1'b1;
      else        sprinkler[zone_q] = 1'b1;
    end
  end

  assign bus.water_supply = (tank_q == T_FILL);
  assign bus.error        = (tank_q == T_FAULT);
  assign bus.alarm        = (tank_q == T_FAULT) | ((lvl_cnt == '0) & (|soil_deb));
  assign bus.sprinkler    = sprinkler;
  assign bus.drip         = drip;
  assign bus.zone_idx     = zone_q;
  assign bus.busy         = (sched_q != S_IDLE);
endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Self-checking bench for irrigation_zone_ctrl: directed scenarios followed by
// randomized sensor activity, all compared every cycle against a behavioural
// model built from the controller's rules.
module tb_irrigation_zone_ctrl;
  localparam int NZ  = 4;
  localparam int NL  = 3;
  localparam int DEB = 4;
  localparam int RB  = 2;
  localparam int SL  = 2;
  localparam int MO  = 8;
  localparam int RC  = 5;
  localparam int ZW  = 2;
  localparam int NIN = NL + 3 * NZ;
  localparam int OW  = 3 + 2 * NZ + ZW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  irrigation_zone_if #(.N_ZONES(NZ), .N_LEVELS(NL)) bus ();

  irrigation_zone_ctrl #(
    .N_ZONES(NZ), .N_LEVELS(NL), .DEB_CYCLES(DEB), .REFILL_BELOW(RB),
    .SPRINK_LEVEL(SL), .MAX_ON_CYCLES(MO), .REST_CYCLES(RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounce: a bit flips when the last DEB synchronised samples all disagree with it.
  // Scheduler: phase 0 idle, 1 watering, 2 resting; m_left counts remaining cycles down.
  logic [NIN-1:0] m_s1, m_s2, m_deb;
  logic [NIN-1:0] m_hist[$];
  bit             m_fill, m_faulted, m_drip;
  int             m_phase, m_zone, m_rr, m_left;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    m_hist.delete();
    m_fill = 0; m_faulted = 0; m_drip = 0;
    m_phase = 0; m_zone = 0; m_rr = 0; m_left = 0;
  endtask

  function automatic int wet_count(input logic [NIN-1:0] d);
    return $countones(d[NL-1:0]);
  endfunction

  function automatic bit bad_pattern(input logic [NIN-1:0] d);
    int c;
    c = wet_count(d);
    return int'(d[NL-1:0]) != ((1 << c) - 1);
  endfunction

  task automatic model_tick();
    logic [NZ-1:0] soil, air, hotz;
    int            cnt;
    bit            flt, got;
    logic [NIN-1:0] raw;
    soil = m_deb[NL +: NZ];
    air  = m_deb[NL + NZ +: NZ];
    hotz = m_deb[NL + 2 * NZ +: NZ];
    cnt  = wet_count(m_deb);
    flt  = bad_pattern(m_deb);
    raw  = {bus.hot, bus.air_dry, bus.soil_dry, bus.level};

    case (m_phase)
      0: if (!flt) begin
        got = 0;
        for (int k = 0; k < NZ; k++) begin
          int z;
          z = (m_rr + k) % NZ;
          if (!got && soil[z] && cnt >= 1) begin
            got = 1; m_phase = 1; m_zone = z; m_rr = (z + 1) % NZ;
            m_drip = hotz[z] | air[z] | (cnt < SL); m_left = MO;
          end
        end
      end
      1: begin
        if (flt || !soil[m_zone] || cnt < (m_drip ? 1 : SL)) m_phase = 0;
        else if (m_left == 1) begin m_phase = 2; m_left = RC; end
        else m_left--;
      end
      default: begin
        if (m_left == 1) m_phase = 0;
        else m_left--;
      end
    endcase

    if (flt) begin m_faulted = 1; m_fill = 0; end
    else if (m_faulted) m_faulted = 0;
    else if (!m_fill && cnt < RB) m_fill = 1;
    else if (m_fill && cnt == NL) m_fill = 0;

    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      for (int i = 0; i < NIN; i++) begin
        bit all_diff;
        all_diff = 1;
        foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) all_diff = 0;
        if (all_diff) m_deb[i] = ~m_deb[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [NZ-1:0] sp, dr;
    bit al;
    sp = '0; dr = '0;
    if (m_phase == 1) begin
      if (m_drip) dr[m_zone] = 1'b1;
      else        sp[m_zone] = 1'b1;
    end
    al = m_faulted | (wet_count(m_deb) == 0 && (|m_deb[NL +: NZ]));
    return {m_fill, m_faulted, al, sp, dr, ZW'(m_zone), (m_phase != 0)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.water_supply, bus.error, bus.alarm, bus.sprinkler, bus.drip, bus.zone_idx, bus.busy};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_tick();
      #1;
      check("cycle_outputs", dut_out(), model_out());
    end
  endtask

  task automatic drive(input logic [NL-1:0] lv, input logic [NZ-1:0] sd,
                       input logic [NZ-1:0] ad, input logic [NZ-1:0] ht);
    bus.level = lv; bus.soil_dry = sd; bus.air_dry = ad; bus.hot = ht;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Step until the valves show exactly the given pattern or the budget runs out.
  task automatic wait_valves(input string tag, input logic [NZ-1:0] sp,
                             input logic [NZ-1:0] dr, input int budget);
    int n;
    n = 0;
    while (!(bus.sprinkler === sp && bus.drip === dr) && n < budget) begin
      step(1);
      n++;
    end
    check(tag, (bus.sprinkler === sp && bus.drip === dr), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  logic [NL-1:0] lv_tab [6];
  int n, m;

  initial begin
    lv_tab = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b101, 3'b010};
    rst_n = 1'b0;
    drive(3'b000, '0, '0, '0);
    model_reset();
    step(2);
    check("reset_state", dut_out(), '0);
    rst_n = 1'b1;

    // Refill hysteresis and its latency through sync + debounce.
    drive(3'b111, '0, '0, '0);
    step(30);
    check("full_tank_valve_closed", bus.water_supply, 1'b0);
    drive(3'b001, '0, '0, '0);
    n = 0;
    do begin step(1); n++; end while (!bus.water_supply && n < 20);
    check("fill_latency", n, 2 + DEB + 1);
    step(10);
    drive(3'b000, '0, '0, '0);
    step(3);
    drive(3'b001, '0, '0, '0);
    step(10);
    check("glitch_ignored", bus.water_supply, 1'b1);
    drive(3'b111, '0, '0, '0);
    step(10);
    check("refill_stops_when_full", bus.water_supply, 1'b0);

    // Inconsistent level pattern.
    drive(3'b101, '0, '0, '0);
    step(12);
    check("fault_error", bus.error, 1'b1);
    check("fault_alarm", bus.alarm, 1'b1);
    check("fault_no_fill", bus.water_supply, 1'b0);
    check("fault_no_valves", bus.sprinkler | bus.drip, '0);
    drive(3'b011, '0, '0, '0);
    step(12);
    check("fault_cleared", bus.error, 1'b0);
    check("no_refill_at_two", bus.water_supply, 1'b0);

    // Round-robin: zone1 first, then zone3.
    do_reset();
    drive(3'b111, 4'b1010, '0, '0);
    wait_valves("rr_zone1_sprinkler", 4'b0010, '0, 40);
    check("rr_zone1_idx", bus.zone_idx, 1);
    drive(3'b111, 4'b1000, '0, '0);
    wait_valves("rr_zone3_sprinkler", 4'b1000, '0, 60);
    check("rr_zone3_idx", bus.zone_idx, 3);

    // Timeout and rest on a hot zone watered by drip.
    drive(3'b111, 4'b0001, '0, 4'b0001);
    wait_valves("hot_zone_drip", '0, 4'b0001, 40);
    n = 0;
    do begin n++; step(1); end while (bus.drip[0] && n < 50);
    check("drip_on_cycles", n, MO);
    m = 0;
    while (bus.busy && (bus.sprinkler | bus.drip) == '0 && m < 50) begin m++; step(1); end
    check("rest_cycles", m, RC);
    step(1);
    check("drip_resumes", bus.drip, 4'b0001);

    // Level drop during a sprinkler run forces a restart as drip.
    drive(3'b011, 4'b0001, '0, '0);
    wait_valves("sprinkler_at_two", 4'b0001, '0, 100);
    drive(3'b001, 4'b0001, '0, '0);
    n = 0;
    while (bus.sprinkler[0] && n < 12) begin step(1); n++; end
    check("sprinkler_aborted", bus.sprinkler, '0);
    step(1);
    check("restart_as_drip", bus.drip, 4'b0001);

    // Asynchronous reset while zone 2 sprinkles; pointer restarts at zone 0.
    drive(3'b111, 4'b0100, '0, '0);
    wait_valves("zone2_sprinkler", 4'b0100, '0, 100);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", dut_out(), '0);
    model_reset();
    drive(3'b111, 4'b0101, '0, '0);
    step(2);
    rst_n = 1'b1;
    wait_valves("rr_restart_zone0", 4'b0001, '0, 40);
    check("rr_restart_idx", bus.zone_idx, 0);

    // Randomized sensor activity with holds long and short enough to hit debounce edges.
    for (int s = 0; s < 60; s++) begin
      drive(lv_tab[$urandom_range(0, 5)], NZ'($urandom_range(0, 15)),
            NZ'($urandom_range(0, 15)), NZ'($urandom_range(0, 15)));
      step($urandom_range(1, 14));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
